// File: rtl/edge_bitmap_packer.sv
// Thresholds one frame of edge pixels to 1 bit each, packs 8 per byte (MSB = leftmost, lines
// never share a byte) and queues the bytes in a first-word-fall-through FIFO for a valid/ready sink.
module edge_bitmap_packer #(
   parameter int WIDTH      = 8,
   parameter int H_RES      = 170,
   parameter int V_RES      = 240,
   parameter int EDGE_TH    = 128,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_start,
   input  logic             i_de,
   input  logic [WIDTH-1:0] i_data,
   output logic [7:0]       o_tx_data,
   output logic             o_tx_valid,
   input  logic             i_tx_ready,
   output logic             o_busy,
   output logic             o_frame_done,
   output logic             o_overflow
);

   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = AW + 1;
   localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);
   localparam logic [WIDTH-1:0] TH       = WIDTH'(EDGE_TH);
   localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

   state_t           state_reg, state_next;
   logic [COL_W-1:0] col_reg;
   logic [ROW_W-1:0] row_reg;
   logic [6:0]       sr_reg;
   logic [2:0]       bit_cnt_reg;
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             overflow_reg, frame_done_reg;
   logic [7:0]       mem [FIFO_DEPTH];

   logic       start_ok, sample, pix_bit, col_last, frame_last, byte_done;
   logic       fifo_empty, pop, push_ok, drop;
   logic [7:0] packed_byte;

   always_comb begin
      start_ok    = (state_reg == IDLE) && i_start;
      sample      = i_de && ((state_reg == ARMED) || (state_reg == CAPTURE));
      pix_bit     = (i_data >= TH);
      col_last    = (col_reg == COL_LAST);
      frame_last  = sample && col_last && (row_reg == ROW_LAST);
      byte_done   = sample && ((bit_cnt_reg == 3'd7) || col_last);
      // A short byte holds bit_cnt+1 bits in its low end; shift them up to the MSB.
      packed_byte = 8'({sr_reg, pix_bit} << (3'd7 - bit_cnt_reg));
      fifo_empty  = (count_reg == '0);
      pop         = !fifo_empty && i_tx_ready;
      push_ok     = byte_done && ((count_reg != FULL_CNT) || pop);
      drop        = byte_done && !push_ok;
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= IDLE;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         frame_done_reg <= (state_reg == DRAIN) && (state_next == IDLE);
      end
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_start) state_next = ARMED;
         ARMED:   if (sample) state_next = frame_last ? DRAIN : CAPTURE;
         CAPTURE: if (frame_last) state_next = DRAIN;
         DRAIN:   if (fifo_empty) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_busy       = (state_reg != IDLE);
      o_frame_done = frame_done_reg;
      o_overflow   = overflow_reg;
      o_tx_valid   = !fifo_empty;
      o_tx_data    = fifo_empty ? 8'h00 : mem[rd_ptr_reg];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col_reg      <= '0;
         row_reg      <= '0;
         sr_reg       <= '0;
         bit_cnt_reg  <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (start_ok) begin
            col_reg     <= '0;
            row_reg     <= '0;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
         end else if (sample) begin
            if (col_last) begin
               col_reg <= '0;
               row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
            end else begin
               col_reg <= col_reg + COL_W'(1);
            end
            if (byte_done) begin
               sr_reg      <= '0;
               bit_cnt_reg <= '0;
            end else begin
               sr_reg      <= {sr_reg[5:0], pix_bit};
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
         end
         if (start_ok)
            overflow_reg <= 1'b0;
         else if (drop)
            overflow_reg <= 1'b1;
      end
   end

   // When full, a same-edge pop frees the slot the write lands in (wr_ptr == rd_ptr).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= packed_byte;
   end

endmodule
